vend_ctrl_param: RTL and testbench

- Parametrised vending-sale controller. Accumulates coin credit against a configurable price and issues a one-cycle vend pulse when the price is met.
- Pays out change, or a full refund on cancel, one unit at a time over a valid/ready handshake to the coin dispenser.
- Sits between the coin acceptor front-end and the dispenser/payout actuators.
- Extends the fixed two-denomination, single-price, single-change-unit sale FSM with these features:
  - configurable price and credit width;
  - arbitrary coin values;
  - cancel/refund;
  - overflow rejection;
  - back-pressured payout.

---
 rtl/vend_ctrl_param.sv | 120 ++++++++++++
 tb/tb_vend_ctrl_param.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_param.sv
// Vending-sale controller: accumulates coin credit toward PRICE, pulses
// vend_vld for one cycle once the price is met, then pays out change (or a
// cancel refund) one unit at a time over a chg_vld/chg_rdy handshake.
module vend_ctrl_param #(
  parameter int unsigned COIN_W   = 2,
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned PRICE    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_vld,
  input  logic [COIN_W-1:0]   coin_val,
  input  logic                cancel,
  output logic                vend_vld,
  output logic                chg_vld,
  input  logic                chg_rdy,
  output logic                refund,
  output logic                coin_acc,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned MAX_CREDIT = (1 << CREDIT_W) - 1;
  localparam int unsigned COIN_MAX   = (1 << COIN_W) - 1;
  localparam int unsigned SUM_W      = CREDIT_W + 1;

  // Reject illegal parameter combinations at elaboration.
  if (PRICE == 0 || PRICE > MAX_CREDIT || COIN_MAX > MAX_CREDIT) begin : g_bad_param
    $error("vend_ctrl_param: illegal PRICE/COIN_W/CREDIT_W combination");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    PAYOUT  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic                refund_nxt;
  logic                acc_nxt;
  logic                rej_nxt;
  logic [SUM_W-1:0]    sum;
  logic                coin_present;

  assign sum          = {1'b0, credit} + SUM_W'(coin_val);
  assign coin_present = coin_vld && (coin_val != '0);

  // State, credit and all outputs are registered; Moore outputs decode next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      credit   <= '0;
      refund   <= 1'b0;
      coin_acc <= 1'b0;
      coin_rej <= 1'b0;
      vend_vld <= 1'b0;
      chg_vld  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      credit   <= credit_nxt;
      refund   <= refund_nxt;
      coin_acc <= acc_nxt;
      coin_rej <= rej_nxt;
      vend_vld <= (state_nxt == VEND);
      chg_vld  <= (state_nxt == PAYOUT);
      busy     <= (state_nxt == VEND) || (state_nxt == PAYOUT);
    end
  end

  // Next-state, credit update and coin accept/reject decision.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    refund_nxt = refund;
    acc_nxt    = 1'b0;
    rej_nxt    = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (cancel && (state == COLLECT)) begin
          // Honoured cancel wins over any coin presented in the same cycle.
          state_nxt  = PAYOUT;
          refund_nxt = 1'b1;
          rej_nxt    = coin_present;
        end else if (coin_present) begin
          if (sum > SUM_W'(MAX_CREDIT)) begin
            rej_nxt = 1'b1;
          end else begin
            acc_nxt    = 1'b1;
            credit_nxt = CREDIT_W'(sum);
            state_nxt  = (sum >= SUM_W'(PRICE)) ? VEND : COLLECT;
          end
        end
      end
      VEND: begin
        rej_nxt    = coin_present;
        credit_nxt = credit - CREDIT_W'(PRICE);
        refund_nxt = 1'b0;
        state_nxt  = (credit_nxt != '0) ? PAYOUT : IDLE;
      end
      PAYOUT: begin
        rej_nxt = coin_present;
        if (chg_rdy) begin
          credit_nxt = credit - CREDIT_W'(1);
          if (credit == CREDIT_W'(1)) begin
            state_nxt  = IDLE;
            refund_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param: PRICE=3 instance for sale/change/refund/
// busy-reject/reset, PRICE=14 instance for credit-overflow rejection.
module tb_vend_ctrl_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_vld, cancel, chg_rdy;
  logic [1:0] coin_val;
  logic       vend_vld, chg_vld, refund, coin_acc, coin_rej, busy;
  logic [3:0] credit;

  logic       coin_vld2;
  logic [1:0] coin_val2;
  logic       cancel2, chg_rdy2;
  logic       vend_vld2, chg_vld2, refund2, coin_acc2, coin_rej2, busy2;
  logic [3:0] credit2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vend_ctrl_param #(.COIN_W(2), .CREDIT_W(4), .PRICE(3)) dut (
    .clk(clk), .rst_n(rst_n), .coin_vld(coin_vld), .coin_val(coin_val),
    .cancel(cancel), .vend_vld(vend_vld), .chg_vld(chg_vld), .chg_rdy(chg_rdy),
    .refund(refund), .coin_acc(coin_acc), .coin_rej(coin_rej), .busy(busy),
    .credit(credit)
  );

  vend_ctrl_param #(.COIN_W(2), .CREDIT_W(4), .PRICE(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .coin_vld(coin_vld2), .coin_val(coin_val2),
    .cancel(cancel2), .vend_vld(vend_vld2), .chg_vld(chg_vld2), .chg_rdy(chg_rdy2),
    .refund(refund2), .coin_acc(coin_acc2), .coin_rej(coin_rej2), .busy(busy2),
    .credit(credit2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Packed view {vend_vld, chg_vld, refund, coin_acc, coin_rej, busy, credit}.
  function automatic logic [9:0] st1();
    return {vend_vld, chg_vld, refund, coin_acc, coin_rej, busy, credit};
  endfunction

  function automatic logic [9:0] st2();
    return {vend_vld2, chg_vld2, refund2, coin_acc2, coin_rej2, busy2, credit2};
  endfunction

  function automatic logic [9:0] exp_v(input logic v, input logic c, input logic r,
                                       input logic a, input logic j, input logic b,
                                       input logic [3:0] cr);
    return {v, c, r, a, j, b, cr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] v);
    coin_vld = 1'b1;
    coin_val = v;
  endtask

  task automatic nocoin();
    coin_vld = 1'b0;
    coin_val = 2'd0;
  endtask

  initial begin
    rst_n = 1'b0; coin_vld = 0; coin_val = 0; cancel = 0; chg_rdy = 0;
    coin_vld2 = 0; coin_val2 = 0; cancel2 = 0; chg_rdy2 = 0;
    step(); step();
    chk("reset_p3",  32'(st1()), 32'(exp_v(0,0,0,0,0,0,4'd0)));
    chk("reset_p14", 32'(st2()), 32'(exp_v(0,0,0,0,0,0,4'd0)));
    rst_n = 1'b1;
    step();

    // Coins 1,1,1: exact price, no change.
    coin(2'd1); step(); chk("t1_c1", 32'(st1()), 32'(exp_v(0,0,0,1,0,0,4'd1)));
    step();             chk("t1_c2", 32'(st1()), 32'(exp_v(0,0,0,1,0,0,4'd2)));
    step();             chk("t1_c3", 32'(st1()), 32'(exp_v(1,0,0,1,0,1,4'd3)));
    nocoin(); step();   chk("t1_done", 32'(st1()), 32'(exp_v(0,0,0,0,0,0,4'd0)));
    step();             chk("t1_idle", 32'(st1()), 32'(exp_v(0,0,0,0,0,0,4'd0)));

    // Coins 2,2: vend then one unit of change under back-pressure.
    coin(2'd2); step(); chk("t2_c1", 32'(st1()), 32'(exp_v(0,0,0,1,0,0,4'd2)));
    step();             chk("t2_vend", 32'(st1()), 32'(exp_v(1,0,0,1,0,1,4'd4)));
    nocoin(); step();   chk("t2_pay", 32'(st1()), 32'(exp_v(0,1,0,0,0,1,4'd1)));
    for (int i = 0; i < 3; i++) begin
      step(); chk("t2_hold", 32'(st1()), 32'(exp_v(0,1,0,0,0,1,4'd1)));
    end
    chg_rdy = 1'b1; step(); chk("t2_xfer", 32'(st1()), 32'(exp_v(0,0,0,0,0,0,4'd0)));
    chg_rdy = 1'b0;

    // Coin 2 then cancel: two-unit refund with chg_rdy toggling 1,0,1.
    coin(2'd2); step(); chk("t3_c1", 32'(st1()), 32'(exp_v(0,0,0,1,0,0,4'd2)));
    nocoin(); cancel = 1'b1;
    step();             chk("t3_cancel", 32'(st1()), 32'(exp_v(0,1,1,0,0,1,4'd2)));
    cancel = 1'b0; chg_rdy = 1'b1;
    step();             chk("t3_r1", 32'(st1()), 32'(exp_v(0,1,1,0,0,1,4'd1)));
    chg_rdy = 1'b0;
    step();             chk("t3_r0", 32'(st1()), 32'(exp_v(0,1,1,0,0,1,4'd1)));
    chg_rdy = 1'b1;
    step();             chk("t3_r2", 32'(st1()), 32'(exp_v(0,0,0,0,0,0,4'd0)));
    chg_rdy = 1'b0;

    // Coins rejected alongside an honoured cancel and while busy.
    coin(2'd1); step(); chk("t4_c1", 32'(st1()), 32'(exp_v(0,0,0,1,0,0,4'd1)));
    coin(2'd3); cancel = 1'b1;
    step();             chk("t4_rej_cancel", 32'(st1()), 32'(exp_v(0,1,1,0,1,1,4'd1)));
    step();             chk("t4_rej_payout", 32'(st1()), 32'(exp_v(0,1,1,0,1,1,4'd1)));
    nocoin(); cancel = 1'b0; chg_rdy = 1'b1;
    step();             chk("t4_refund", 32'(st1()), 32'(exp_v(0,0,0,0,0,0,4'd0)));
    chg_rdy = 1'b0;
    coin(2'd3); step(); chk("t4_vend", 32'(st1()), 32'(exp_v(1,0,0,1,0,1,4'd3)));
    cancel = 1'b1;
    step();             chk("t4_rej_vend", 32'(st1()), 32'(exp_v(0,0,0,0,1,0,4'd0)));
    nocoin(); cancel = 1'b0;
    step();             chk("t4_idle", 32'(st1()), 32'(exp_v(0,0,0,0,0,0,4'd0)));

    // PRICE=14: reach 13, overflowing coin rejected, then exact coin vends.
    coin_vld2 = 1'b1; coin_val2 = 2'd3;
    for (int i = 0; i < 4; i++) step();
    coin_val2 = 2'd1;
    step();             chk("t5_13", 32'(st2()), 32'(exp_v(0,0,0,1,0,0,4'd13)));
    coin_val2 = 2'd3;
    step();             chk("t5_ovf", 32'(st2()), 32'(exp_v(0,0,0,0,1,0,4'd13)));
    coin_val2 = 2'd1;
    step();             chk("t5_vend", 32'(st2()), 32'(exp_v(1,0,0,1,0,1,4'd14)));
    coin_vld2 = 1'b0; coin_val2 = 2'd0;
    step();             chk("t5_done", 32'(st2()), 32'(exp_v(0,0,0,0,0,0,4'd0)));

    // Async reset mid-PAYOUT with credit 2.
    coin(2'd2); step();
    coin(2'd3); step(); chk("t6_vend", 32'(st1()), 32'(exp_v(1,0,0,1,0,1,4'd5)));
    nocoin(); step();   chk("t6_pay", 32'(st1()), 32'(exp_v(0,1,0,0,0,1,4'd2)));
    #2 rst_n = 1'b0;
    #1 chk("t6_async", 32'(st1()), 32'(exp_v(0,0,0,0,0,0,4'd0)));
    step();
    rst_n = 1'b1;
    step();             chk("t6_idle", 32'(st1()), 32'(exp_v(0,0,0,0,0,0,4'd0)));
    coin_vld = 1'b1; coin_val = 2'd0;
    step();             chk("t6_zero_coin", 32'(st1()), 32'(exp_v(0,0,0,0,0,0,4'd0)));
    nocoin(); step();   chk("t6_quiet", 32'(st1()), 32'(exp_v(0,0,0,0,0,0,4'd0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
